// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests a sync-read imem, absorbs
// its one-cycle latency with a one-entry skid buffer and drives IF/ID.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   stall_id           hold IF/ID contents this cycle
//   redirect_valid     control-flow change, flush younger instructions
//   redirect_pc        new fetch address (bits [1:0] ignored)
//   imem_req/addr      read request and address (= pc_f)
//   imem_rdata         data for the request issued the previous cycle
//   id_valid/inst/pc   IF/ID register contents
//   id_pc_plus4        id_pc + 4, wrapping
module fetch_stage #(
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter logic [INST_WIDTH-1:0] NOP_INST = 'h13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_id,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  id_valid,
  output logic [INST_WIDTH-1:0] id_inst,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [ADDR_WIDTH-1:0] id_pc_plus4
);

  localparam logic [ADDR_WIDTH-1:0] FOUR = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  typedef struct packed {
    logic                  valid;
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc4;
  } if_id_t;

  function automatic if_id_t mk_slot(
    input logic [INST_WIDTH-1:0] inst,
    input logic [ADDR_WIDTH-1:0] pc
  );
    if_id_t s;
    s.valid = 1'b1;
    s.inst  = inst;
    s.pc    = pc;
    s.pc4   = pc + FOUR;
    return s;
  endfunction

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [INST_WIDTH-1:0] skid_inst_q, skid_inst_d;
  logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
  if_id_t                ifid_q, ifid_d;
  logic                  skid_next_full;

  // A new request is only issued if its response is sure to find room
  // (IF/ID or an empty skid) in the following cycle.
  assign skid_next_full =
    (stall_id & (skid_valid_q | inflight_q)) |
    (skid_valid_q & inflight_q);

  assign imem_req  = ~redirect_valid & ~skid_next_full;
  assign imem_addr = pc_q;

  always_comb begin
    pc_d         = pc_q;
    inflight_d   = 1'b0;
    req_pc_d     = req_pc_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    ifid_d       = ifid_q;

    if (redirect_valid) begin
      // Flush everything; any response arriving now is dropped.
      pc_d         = redirect_pc & ALIGN_MASK;
      skid_valid_d = 1'b0;
      ifid_d.valid = 1'b0;
      ifid_d.inst  = NOP_INST;
    end else begin
      if (imem_req) begin
        req_pc_d   = pc_q;
        pc_d       = pc_q + FOUR;
        inflight_d = 1'b1;
      end

      if (!stall_id) begin
        if (skid_valid_q) begin
          ifid_d = mk_slot(skid_inst_q, skid_pc_q);
        end else if (inflight_q) begin
          ifid_d = mk_slot(imem_rdata, req_pc_q);
        end else begin
          ifid_d.valid = 1'b0;
          ifid_d.inst  = NOP_INST;
        end
        // Skid drained into IF/ID; a concurrent response refills it.
        skid_valid_d = skid_valid_q & inflight_q;
        if (skid_valid_q & inflight_q) begin
          skid_inst_d = imem_rdata;
          skid_pc_d   = req_pc_q;
        end
      end else if (inflight_q) begin
        // Stalled: skid is known empty here, park the response.
        skid_valid_d = 1'b1;
        skid_inst_d  = imem_rdata;
        skid_pc_d    = req_pc_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      inflight_q   <= 1'b0;
      req_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= NOP_INST;
      skid_pc_q    <= '0;
      ifid_q.valid <= 1'b0;
      ifid_q.inst  <= NOP_INST;
      ifid_q.pc    <= '0;
      ifid_q.pc4   <= FOUR;
    end else begin
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      req_pc_q     <= req_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
      ifid_q       <= ifid_d;
    end
  end

  assign id_valid    = ifid_q.valid;
  assign id_inst     = ifid_q.inst;
  assign id_pc       = ifid_q.pc;
  assign id_pc_plus4 = ifid_q.pc4;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage core. It owns the PC, issues requests to a synchronous-read instruction memory, and absorbs its one-cycle read latency with a one-entry skid buffer. It drives the IF/ID pipeline register that feeds the ID-stage decoder. It honours `stall_id` from hazard detection and `redirect_valid` from branch/jump resolution, never dropping or duplicating an instruction.

## Interface
- `INST_WIDTH`, 32, instruction width
- `ADDR_WIDTH`, 32, PC/address width
- `RESET_PC`, 0, first fetch address after reset
- `NOP_INST`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `stall_id`  in  1  hold IF/ID contents this cycle
- `redirect_valid`  in  1  control-flow change; flush younger instructions
- `redirect_pc`  in  ADDR_WIDTH  new fetch address; bits [1:0] treated as 0
- `imem_req`  out  1  read request this cycle
- `imem_addr`  out  ADDR_WIDTH  read address (= `pc_f`)
- `imem_rdata`  in  INST_WIDTH  data for the request issued the previous cycle
- `id_valid`  out  1  IF/ID holds a real instruction
- `id_inst`  out  INST_WIDTH  instruction to decoder
- `id_pc`  out  ADDR_WIDTH  PC of `id_inst`
- `id_pc_plus4`  out  ADDR_WIDTH  `id_pc + 4`, modulo 2^ADDR_WIDTH

## Operation
- State:
  - `pc_f`: next address to request.
  - `inflight`, `req_pc`: a request issued last cycle and its address.
  - `skid_valid`, `skid_inst`, `skid_pc`: skid buffer.
  - IF/ID outputs.
- A response is present this cycle iff `inflight`=1. Its data is `imem_rdata` and its PC is `req_pc`.
- `skid_next_full` = (`stall_id` & (`skid_valid` | `inflight`)) | (`skid_valid` & `inflight`).
- `imem_req` = !`redirect_valid` & !`skid_next_full`. A request is issued only when space for its response is guaranteed.
- Issue: when `imem_req`=1, `req_pc`<=`pc_f`, `pc_f`<=`pc_f`+4 (wraps modulo 2^ADDR_WIDTH), `inflight`<=1. Otherwise `inflight`<=0 and `pc_f` holds.
- Redirect has priority over everything:
  - `pc_f`<=`redirect_pc` with [1:0] forced to 0.
  - `inflight`<=0; the response arriving this cycle is discarded.
  - `skid_valid`<=0.
  - IF/ID<=bubble, even if `stall_id`=1.
- No redirect, `stall_id`=0:
  - IF/ID loads from the skid if `skid_valid`.
  - Otherwise IF/ID loads the response if `inflight`.
  - Otherwise IF/ID loads a bubble.
  - If the skid drained and a response is present, the response enters the skid.
- No redirect, `stall_id`=1: IF/ID holds. A present response enters the skid; the skid is guaranteed empty by the request rule.
- Bubble: `id_valid`=0, `id_inst`=`NOP_INST`, `id_pc`/`id_pc_plus4` hold their previous values.
- Invariant: instructions reach IF/ID in strict program order. Each is delivered exactly once. Skid overflow is a design error and is flagged by an assertion in the bench.

## Timing
- Reset (asynchronous, immediate): `pc_f`=`RESET_PC`, `inflight`=0, `skid_valid`=0, `id_valid`=0, `id_inst`=`NOP_INST`, `id_pc`=0, `id_pc_plus4`=4.
- `imem_req` and `imem_addr` are combinational from state and inputs. In the first cycle after reset release, `imem_req`=1 and `imem_addr`=`RESET_PC`.
- Latency: a request issued in cycle N returns data in cycle N+1 and appears on `id_*` in cycle N+2. Steady-state throughput is one instruction per cycle.
- Stall release: the oldest held instruction (skid first, then response) enters IF/ID on the first unstalled edge. No extra bubble is inserted if the skid was full.
- Redirect in cycle N: `imem_req`=0 in N; the request to `redirect_pc` is issued in N+1. `id_valid`=0 in N+1 and N+2; the target appears in N+3.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately. Any pending memory response is ignored because `inflight`=0.

## Test plan
- Reset release, `RESET_PC`=0x100, no stalls, memory returns addr-tagged words -> `imem_addr` 0x100, 0x104, …; `id_valid` rises 2 cycles after release; `id_pc` 0x100, 0x104, … consecutive with `id_pc_plus4`=`id_pc`+4.
- `stall_id` high 3 cycles mid-stream -> `id_*` frozen, `imem_req` low after skid fills. On release, the sequence continues with no gap, no duplicate, no skip.
- `redirect_valid` with `redirect_pc`=0x200 while streaming -> exactly 2 bubble cycles (`id_inst`=0x00000013). Then `id_pc`=0x200, 0x204; the response in flight at redirect never appears.
- `redirect_valid` and `stall_id` both high while the skid is full -> skid flushed, IF/ID becomes a bubble, next valid `id_pc`=`redirect_pc`.
- `redirect_pc`=0xFFFF_FFFE -> fetch at 0xFFFF_FFFC, then 0x0000_0000 (wrap); `id_pc_plus4` of 0xFFFF_FFFC is 0.
- `rst` asserted in the middle of a stall -> outputs reach reset values without waiting for a clock edge; after release, fetch restarts at `RESET_PC` with no stale instruction.
